// File: rtl/checksum_stream.sv
// Streaming checksum generator/checker.
// Packs p_IN_LEN-bit beats big-endian into p_WORD_LEN-bit words and folds each
// completed word into a per-packet accumulator (one's-complement, two's-complement
// or XOR). The final checksum is held with a valid/ack handshake; when the last
// beat asks for check mode, o_ok reports whether the packet (checksum included)
// folds to the mode's identity value.

// One lane of the word assembler: the active lane takes the incoming beat,
// every other lane keeps what the word register already holds.
module checksum_lane #(
  parameter int p_IN_LEN = 8
) (
  input  logic                sel,
  input  logic [p_IN_LEN-1:0] held,
  input  logic [p_IN_LEN-1:0] beat,
  output logic [p_IN_LEN-1:0] merged
);
  assign merged = sel ? beat : held;
endmodule

module checksum_stream #(
  parameter int p_WORD_LEN = 16,
  parameter int p_IN_LEN   = 8,
  parameter int p_MODE     = 0,
  parameter int p_CNT_LEN  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [p_IN_LEN-1:0]   i_data,
  input  logic                  i_valid,
  input  logic                  i_last,
  input  logic                  i_verify,
  output logic                  o_ready,
  output logic [p_WORD_LEN-1:0] o_checksum,
  output logic                  o_ok,
  output logic                  o_valid,
  input  logic                  i_ack,
  output logic [p_CNT_LEN-1:0]  o_word_cnt
);
  localparam int N      = p_WORD_LEN / p_IN_LEN;
  localparam int LANE_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_ACCUM = 2'd0;
  localparam logic [1:0] S_FIN   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]                     state;
  logic [N-1:0][p_IN_LEN-1:0]     word_q;   // lane 0 sits in the top slice
  logic [N-1:0][p_IN_LEN-1:0]     word_d;
  logic [LANE_W-1:0]              lane;
  logic [p_WORD_LEN-1:0]          acc;
  logic [p_WORD_LEN-1:0]          acc_nxt;
  logic [p_WORD_LEN-1:0]          word_w;
  logic [p_WORD_LEN:0]            sum_ext;
  logic [p_WORD_LEN-1:0]          fin_cks;
  logic                           fin_ok;
  logic                           verify_q;
  logic                           accept;
  logic                           word_done;

  // Ready depends only on state and reset, never on i_valid.
  assign o_ready   = (state == S_ACCUM) && !i_reset;
  assign o_valid   = (state == S_DONE);
  assign accept    = i_valid && o_ready;
  assign word_done = accept && ((lane == LANE_W'(N-1)) || i_last);

  // Word assembly: lanes above the current one still hold this word's earlier
  // beats, lanes below are zero because the register clears per word, which
  // gives the zero padding of a short final word for free.
  for (genvar g = 0; g < N; g++) begin : g_lane
    checksum_lane #(.p_IN_LEN(p_IN_LEN)) u_lane (
      .sel    (lane == LANE_W'(g)),
      .held   (word_q[N-1-g]),
      .beat   (i_data),
      .merged (word_d[N-1-g])
    );
  end

  assign word_w  = word_d;
  assign sum_ext = {1'b0, acc} + {1'b0, word_w};

  // Fold the completed word into the accumulator for the selected arithmetic.
  always_comb begin
    acc_nxt = acc ^ word_w;
    if (p_MODE == 0)
      acc_nxt = sum_ext[p_WORD_LEN-1:0] + {{(p_WORD_LEN-1){1'b0}}, sum_ext[p_WORD_LEN]};
    else if (p_MODE == 1)
      acc_nxt = sum_ext[p_WORD_LEN-1:0];
  end

  // Final checksum and the identity test used in check mode.
  always_comb begin
    fin_cks = acc;
    fin_ok  = (acc == '0);
    if (p_MODE == 0) begin
      fin_cks = ~acc;
      fin_ok  = (acc == '1);
    end else if (p_MODE == 1) begin
      fin_cks = p_WORD_LEN'(0) - acc;
    end
  end

  // Packet FSM, accumulator, lane/word bookkeeping and result registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= S_ACCUM;
      word_q     <= '0;
      lane       <= '0;
      acc        <= '0;
      verify_q   <= 1'b0;
      o_checksum <= '0;
      o_ok       <= 1'b0;
      o_word_cnt <= '0;
    end else begin
      case (state)
        S_ACCUM: begin
          if (accept) begin
            if (word_done) begin
              acc    <= acc_nxt;
              word_q <= '0;
              lane   <= '0;
              if (o_word_cnt != '1) o_word_cnt <= o_word_cnt + 1'b1;
            end else begin
              word_q <= word_d;
              lane   <= lane + 1'b1;
            end
            if (i_last) begin
              verify_q <= i_verify;
              state    <= S_FIN;
            end
          end
        end
        S_FIN: begin
          o_checksum <= fin_cks;
          // Only a check-mode packet can report a good match.
          o_ok       <= fin_ok && verify_q;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (i_ack) begin
            acc        <= '0;
            lane       <= '0;
            o_word_cnt <= '0;
            state      <= S_ACCUM;
          end
        end
        default: state <= S_ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_checksum_stream.sv
// Bench for checksum_stream: three instances (one per arithmetic mode, the XOR
// one with a 3-bit word counter to reach saturation) share one input stream.
// A packet-level reference computes checksums from the byte list directly.
module tb_checksum_stream;
  typedef logic [7:0] byte_t;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  i_data = 8'h00;
  logic        i_valid = 1'b0, i_last = 1'b0, i_verify = 1'b0, i_ack = 1'b0;

  logic        rdy0, rdy1, rdy2, vld0, vld1, vld2, ok0, ok1, ok2;
  logic [15:0] cks0, cks1, cks2, cnt0, cnt1;
  logic [2:0]  cnt2;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  checksum_stream #(.p_WORD_LEN(16), .p_IN_LEN(8), .p_MODE(0), .p_CNT_LEN(16)) u0 (
    .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .i_verify(i_verify), .o_ready(rdy0), .o_checksum(cks0), .o_ok(ok0), .o_valid(vld0),
    .i_ack(i_ack), .o_word_cnt(cnt0));
  checksum_stream #(.p_WORD_LEN(16), .p_IN_LEN(8), .p_MODE(1), .p_CNT_LEN(16)) u1 (
    .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .i_verify(i_verify), .o_ready(rdy1), .o_checksum(cks1), .o_ok(ok1), .o_valid(vld1),
    .i_ack(i_ack), .o_word_cnt(cnt1));
  checksum_stream #(.p_WORD_LEN(16), .p_IN_LEN(8), .p_MODE(2), .p_CNT_LEN(3)) u2 (
    .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .i_verify(i_verify), .o_ready(rdy2), .o_checksum(cks2), .o_ok(ok2), .o_valid(vld2),
    .i_ack(i_ack), .o_word_cnt(cnt2));

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%h expected=%h t=%0t", name, k, act, exp, $time);
    end
  endtask

  // ---------------- reference ----------------
  // Folded value of a byte list: big-endian 16-bit words, odd tail zero-padded.
  function automatic int unsigned ref_acc(input byte_t q[$], input int mode);
    int unsigned a = 0;
    int unsigned w;
    for (int i = 0; i < q.size(); i += 2) begin
      w = q[i] * 256 + ((i + 1 < q.size()) ? q[i+1] : 0);
      if (mode == 0) begin
        a = a + w;
        if (a > 65535) a = a - 65535;
      end else if (mode == 1) a = (a + w) % 65536;
      else a = a ^ w;
    end
    return a;
  endfunction

  function automatic logic [15:0] ref_cks(input byte_t q[$], input int mode);
    int unsigned a = ref_acc(q, mode);
    if (mode == 0) return 16'(65535 - a);
    if (mode == 1) return 16'((65536 - a) % 65536);
    return 16'(a);
  endfunction

  function automatic bit ref_ok(input byte_t q[$], input int mode);
    int unsigned a = ref_acc(q, mode);
    return (mode == 0) ? (a == 65535) : (a == 0);
  endfunction

  // Packet progress: 0 = taking beats, 1 = finishing, 2 = result offered.
  byte_t       mb[$];
  int          m_phase = 0;
  bit          m_verify = 0;
  bit          started = 0;
  logic [15:0] m_cks [3];
  bit          m_ok  [3];
  int          cnt_max [3] = '{65535, 65535, 7};

  always @(posedge i_clk) begin
    if (i_reset) begin
      mb.delete();
      m_phase = 0;
      m_verify = 0;
      for (int k = 0; k < 3; k++) begin m_cks[k] = '0; m_ok[k] = 0; end
      started = 1;
    end else begin
      case (m_phase)
        0: if (i_valid) begin
             mb.push_back(i_data);
             if (i_last) begin m_verify = i_verify; m_phase = 1; end
           end
        1: begin
             for (int k = 0; k < 3; k++) begin m_cks[k] = ref_cks(mb, k); m_ok[k] = ref_ok(mb, k); end
             m_phase = 2;
           end
        default: if (i_ack) begin mb.delete(); m_phase = 0; end
      endcase
    end
  end

  function automatic int exp_cnt(input int k);
    int n = (m_phase == 0) ? mb.size() / 2 : (mb.size() + 1) / 2;
    return (n > cnt_max[k]) ? cnt_max[k] : n;
  endfunction

  // Every cycle: compare all outputs of all three instances with the reference.
  always @(negedge i_clk) begin
    if (started) begin
      logic [31:0] a_rdy [3];
      logic [31:0] a_vld [3];
      logic [31:0] a_cks [3];
      logic [31:0] a_cnt [3];
      logic [31:0] a_ok  [3];
      a_rdy = '{32'(rdy0), 32'(rdy1), 32'(rdy2)};
      a_vld = '{32'(vld0), 32'(vld1), 32'(vld2)};
      a_cks = '{32'(cks0), 32'(cks1), 32'(cks2)};
      a_cnt = '{32'(cnt0), 32'(cnt1), 32'(cnt2)};
      a_ok  = '{32'(ok0),  32'(ok1),  32'(ok2)};
      for (int k = 0; k < 3; k++) begin
        chk("ready", k, a_rdy[k], 32'((m_phase == 0) && !i_reset));
        chk("valid", k, a_vld[k], 32'(m_phase == 2));
        chk("checksum", k, a_cks[k], 32'(m_cks[k]));
        chk("word_cnt", k, a_cnt[k], 32'(exp_cnt(k)));
        if (m_phase == 2 && m_verify) chk("ok", k, a_ok[k], 32'(m_ok[k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] cap_cnt [3];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (m_phase != p && n < 50) begin tick(); n++; end
    if (m_phase != p) chk("wait_phase", 0, 32'(m_phase), 32'(p));
  endtask

  // ack_dly < 0 holds i_ack high for the whole packet.
  task automatic send_pkt(input byte_t b[$], input bit verify, input int ack_dly,
                          input bit hold_valid, input bit gaps);
    wait_phase(0);
    if (ack_dly < 0) i_ack = 1'b1;
    for (int i = 0; i < b.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        i_valid = 1'b0; i_last = 1'($urandom); tick();
      end
      i_valid  = 1'b1;
      i_data   = b[i];
      i_last   = (i == b.size() - 1);
      i_verify = (i == b.size() - 1) ? verify : 1'($urandom);
      tick();
    end
    i_valid = hold_valid;
    i_last  = hold_valid;
    i_data  = 8'($urandom);
    wait_phase(2);
    cap_cnt[0] = cnt0; cap_cnt[1] = cnt1; cap_cnt[2] = 16'(cnt2);
    if (ack_dly < 0) begin
      tick();
    end else begin
      for (int i = 0; i < ack_dly; i++) tick();
      i_ack = 1'b1;
      tick();
    end
    i_ack = 1'b0; i_valid = 1'b0; i_last = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    byte_t pk[$];
    int len, mode;
    tick(); tick();
    chk("reset_checksum", 0, 32'(cks0), 32'h0);
    chk("reset_ready", 0, 32'(rdy0), 32'h0);
    i_reset = 1'b0;
    tick();

    // Classic IPv4-style example and the other two modes on the same bytes.
    pk = '{8'h45, 8'h00, 8'h00, 8'h1C};
    send_pkt(pk, 1'b0, 0, 1'b0, 1'b0);
    chk("lit_m0", 0, 32'(cks0), 32'hBAE3);
    chk("lit_m1", 1, 32'(cks1), 32'hBAE4);
    chk("lit_m2", 2, 32'(cks2), 32'h451C);
    chk("lit_cnt", 0, 32'(cap_cnt[0]), 32'd2);

    pk = '{8'hFF, 8'hFF, 8'h00, 8'h01};
    send_pkt(pk, 1'b0, 1, 1'b0, 1'b0);
    chk("lit_carry", 0, 32'(cks0), 32'hFFFE);

    pk = '{8'h12, 8'h34, 8'h56};
    send_pkt(pk, 1'b0, 0, 1'b0, 1'b0);
    chk("lit_odd", 0, 32'(cks0), 32'h97CB);
    chk("lit_odd_cnt", 0, 32'(cap_cnt[0]), 32'd2);

    pk = '{8'h45, 8'h00, 8'h00, 8'h1C, 8'hBA, 8'hE3};
    send_pkt(pk, 1'b1, 0, 1'b0, 1'b0);
    chk("lit_verify_ok", 0, 32'(ok0), 32'h1);
    pk = '{8'h45, 8'h01, 8'h00, 8'h1C, 8'hBA, 8'hE3};
    send_pkt(pk, 1'b1, 0, 1'b0, 1'b0);
    chk("lit_verify_bad", 0, 32'(ok0), 32'h0);
    pk = '{8'h45, 8'h00, 8'h00, 8'h1C, 8'hBA, 8'hE4};
    send_pkt(pk, 1'b1, 0, 1'b0, 1'b0);
    chk("lit_verify_m1", 1, 32'(ok1), 32'h1);
    pk = '{8'h45, 8'h00, 8'h00, 8'h1C, 8'h45, 8'h1C};
    send_pkt(pk, 1'b1, 0, 1'b0, 1'b0);
    chk("lit_verify_m2", 2, 32'(ok2), 32'h1);

    // i_valid held through FIN/DONE, late ack; then ack held high (one-cycle DONE).
    pk = '{8'hA5, 8'h5A, 8'h33};
    send_pkt(pk, 1'b0, 5, 1'b1, 1'b0);
    pk = '{8'h01};
    send_pkt(pk, 1'b0, -1, 1'b1, 1'b0);
    chk("lit_single", 0, 32'(cks0), 32'hFEFF);

    // Abandon a packet with reset after three beats.
    wait_phase(0);
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1; i_data = 8'(8'h77 + i); i_last = 1'b0; tick();
    end
    i_reset = 1'b1; tick();
    i_reset = 1'b0; i_valid = 1'b0; tick();
    pk = '{8'h12, 8'h34};
    send_pkt(pk, 1'b0, 0, 1'b0, 1'b0);
    chk("lit_after_reset", 0, 32'(cks0), 32'hEDCB);

    // Long packet: 10 words, 3-bit counter saturates at 7.
    pk.delete();
    for (int i = 0; i < 20; i++) pk.push_back(8'(i * 13 + 1));
    send_pkt(pk, 1'b0, 0, 1'b0, 1'b0);
    chk("lit_sat", 2, 32'(cap_cnt[2]), 32'd7);
    chk("lit_nosat", 0, 32'(cap_cnt[0]), 32'd10);

    // Random packets, some carrying a correct checksum for one mode.
    for (int p = 0; p < 60; p++) begin
      pk.delete();
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) pk.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        if (pk.size() % 2 == 1) pk.push_back(8'($urandom));
        mode = $urandom_range(0, 2);
        pk.push_back(ref_cks(pk, mode) >> 8);
        pk.push_back(8'(ref_cks(pk[0:pk.size()-2], mode)));
        if ($urandom_range(0, 3) == 0) pk[0] = pk[0] ^ 8'h10;
        send_pkt(pk, 1'b1, $urandom_range(0, 3), 1'($urandom), 1'($urandom));
      end else begin
        send_pkt(pk, 1'($urandom), $urandom_range(0, 3) - 1, 1'($urandom), 1'($urandom));
      end
    end

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
